// File: rtl/sseg_arb_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
package sseg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    SWITCH = 2'd2
  } arb_state_t;

  localparam int DISP_W = 16;

  localparam logic HEX_MODE = 1'b0;
  localparam logic DEC_MODE = 1'b1;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester strictly after ptr,
// wrapping, found by a priority search over a doubled request vector.
module rr_picker #(
  parameter int NUM_REQ = 4,
  localparam int PTR_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic               valid
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [2*NUM_REQ-1:0] mask;
  logic [2*NUM_REQ-1:0] masked;
  logic                 found;

  // Window ptr+1 .. ptr+NUM_REQ over the doubled vector, lowest set bit wins.
  always_comb begin
    dbl    = {req, req};
    mask   = '0;
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < 2*NUM_REQ; i++) begin
      if (i > int'(ptr) && i <= int'(ptr) + NUM_REQ) mask[i] = 1'b1;
    end
    masked = dbl & mask;
    for (int i = 0; i < 2*NUM_REQ; i++) begin
      if (masked[i] && !found) begin
        found = 1'b1;
        if (i < NUM_REQ) winner[i] = 1'b1;
        else             winner[i-NUM_REQ] = 1'b1;
      end
    end
    valid = |req;
  end

endmodule

// File: rtl/sseg_display_arbiter.sv
// Round-robin owner of the shared seven-segment display datapath.
//
// state  | meaning
// IDLE   | no owner, display shows last value
// HOLD   | owner granted, display tracks owner's data/mode
// SWITCH | one-cycle gap between owners, grant dropped
module sseg_display_arbiter
  import sseg_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DISP_W-1:0] data,
  input  logic [NUM_REQ-1:0]        mode,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [DISP_W-1:0]         disp_data,
  output logic                      disp_mode,
  output logic                      busy
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_INIT = PTR_W'(NUM_REQ - 1);

  arb_state_t          state, state_nxt;
  logic [PTR_W-1:0]    ptr, ptr_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [NUM_REQ-1:0]  gnt_nxt;
  logic                busy_nxt;
  logic [DISP_W-1:0]   disp_data_nxt;
  logic                disp_mode_nxt;

  logic [NUM_REQ-1:0]  win_oh;
  logic                win_vld;
  logic [PTR_W-1:0]    win_idx;
  logic [DISP_W-1:0]   owner_data;
  logic                owner_mode;
  logic                owner_req;
  logic                other_req;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req    (req),
    .ptr    (ptr),
    .winner (win_oh),
    .valid  (win_vld)
  );

  // One-hot winner to index, stored as the new round-robin pointer.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_oh[i]) win_idx = PTR_W'(i);
    end
  end

  // Mux the current owner's data and mode using the registered grant.
  always_comb begin
    owner_data = '0;
    owner_mode = HEX_MODE;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        owner_data = data[i*DISP_W +: DISP_W];
        owner_mode = mode[i];
      end
    end
  end

  assign owner_req = |(req & gnt);
  assign other_req = |(req & ~gnt);

  // Next-state and next-output logic; release beats expiry when both apply.
  always_comb begin
    state_nxt     = state;
    gnt_nxt       = gnt;
    busy_nxt      = busy;
    ptr_nxt       = ptr;
    cnt_nxt       = cnt;
    disp_data_nxt = disp_data;
    disp_mode_nxt = disp_mode;
    case (state)
      IDLE, SWITCH: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        busy_nxt  = 1'b0;
        if (win_vld) begin
          state_nxt = HOLD;
          gnt_nxt   = win_oh;
          busy_nxt  = 1'b1;
          ptr_nxt   = win_idx;
          cnt_nxt   = CNT_LOAD;
        end
      end
      HOLD: begin
        disp_data_nxt = owner_data;
        disp_mode_nxt = owner_mode;
        if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
        if (!owner_req || (cnt == '0 && other_req)) begin
          state_nxt = SWITCH;
          gnt_nxt   = '0;
          busy_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State, counter, pointer and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= PTR_INIT;
      cnt       <= '0;
      gnt       <= '0;
      busy      <= 1'b0;
      disp_data <= '0;
      disp_mode <= HEX_MODE;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      cnt       <= cnt_nxt;
      gnt       <= gnt_nxt;
      busy      <= busy_nxt;
      disp_data <= disp_data_nxt;
      disp_mode <= disp_mode_nxt;
    end
  end

endmodule
